alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Multi-cycle datapath front/back end around the RISC machine ALU: owns the 8x16 register file, the A/B operand latches, the B-path shifter, the C result register and the Z status flag. Accepts one decoded instruction per handshake and presents operands and `alu_op` to the ALU. It captures `alu_out`/`alu_z` and writes the result back to the register file.

## Interface
- No parameters; data width fixed at 16 bits, 8 registers.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: high only in IDLE.
- `in_kind` in 2: 00 ALU-reg, 01 MOV-reg, 10 MOV-imm, 11 reserved (no-op).
- `in_aluop` in 2: ALU operation (00 ADD, 01 CMP/SUB, 10 AND, 11 MVN).
- `in_rn`, `in_rm`, `in_rd` in 3 each: register indices.
- `in_shift` in 2: B-path shift (00 none, 01 LSL1, 10 LSR1, 11 ASR1).
- `in_imm8` in 8: immediate for MOV-imm, sign-extended to 16.
- `alu_a`, `alu_b` out 16: operands to ALU.
- `alu_op` out 2: operation to ALU.
- `alu_out` in 16, `alu_z` in 1: ALU result and zero flag (combinational from ALU).
- `c_out` out 16: C result register.
- `z_flag` out 1: status Z register.
- `done` out 1: one-cycle pulse on instruction completion.
- `dbg_sel` in 3, `dbg_data` out 16: combinational read of R[dbg_sel].

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
- IDLE: `in_ready`=1. On `in_valid`: latch all `in_*` fields; kind 00/01 -> LOAD_A; kind 10 -> WRITE with C <= sext(imm8); kind 11 -> WRITE.
- LOAD_A: A <= R[rn] (kind 00) or 16'h0000 (kind 01). -> LOAD_B.
- LOAD_B: B <= R[rm]. -> EXEC.
- EXEC: C <= `alu_out`. Z <= `alu_z` for kind 00 only; kind 01 leaves Z unchanged. -> WRITE.
- WRITE: `done`=1. R[rd] <= C, except kind 00 with aluop 01 (CMP) and kind 11, which do not write. -> IDLE.
- `alu_a` = A; `alu_b` = shift(B, latched shift); `alu_op` = latched aluop for kind 00, 00 for kind 01. These outputs are driven in every state, but the results are sampled only in EXEC.
- Shift: LSL1 = {B[14:0],0}; LSR1 = {0,B[15:1]}; ASR1 = {B[15],B[15:1]}.
- Arithmetic is modulo 2^16; no carry/overflow flags.

## Timing
- Reset (any state, including mid-instruction) sets the following for the next cycle: state IDLE; R0-R7, A, B and C all 0; Z=0; `done`=0; `in_ready`=1; `alu_a`=`alu_b`=0; `alu_op`=00. An aborted instruction never writes.
- Latency from accept edge to `done` high: 4 cycles for kinds 00/01 and 1 cycle for kinds 10/11. The register write and `done` occur in the same cycle; the new value is visible on `dbg_data` after that edge.
- Next accept is possible in the cycle after `done` (IDLE); throughput is 1 instruction per 5 cycles (ALU) or 2 cycles (MOV-imm).
- `in_valid` and `in_*` are ignored while `in_ready`=0. Fields are sampled only at accept.
- Overlapping indices are legal: rd==rn==rm uses old values, because reads precede WRITE.

## Test plan
- Reset, MOV-imm r0,#5, then MOV-imm r1,#0xFE -> R0=0x0005, R1=0xFFFE, `c_out`=0xFFFE; `done` 1 cycle after each accept.
- ALU ADD r2=r0+(r1 LSL1) -> `alu_b`=0xFFFC in EXEC, R2=0x0001, `z_flag`=0, `done` 4 cycles after accept.
- CMP r0,r0 -> `z_flag`=1, R0..R7 unchanged, `c_out`=0x0000. Then MOV-reg r3,r1 ASR1 -> R3=0xFFFF and `z_flag` stays 1.
- MVN r4,r0 -> R4=0xFFFA. AND r5=r0&r4 -> R5=0x0000, `z_flag`=1.
- Hold `in_valid`=1 with changing fields during LOAD_A..WRITE -> exactly one instruction executes, using the fields sampled at accept.
- Assert `reset` in EXEC of ADD r6 -> no write to R6, all registers 0, `in_ready`=1 and `done`=0 in the following cycle.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Multi-cycle register file / operand sequencer around an external ALU.
// Revision : 1.0  initial release
// ============================================================================
module alu_operand_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [1:0]  in_aluop,
   input  logic [2:0]  in_rn,
   input  logic [2:0]  in_rm,
   input  logic [2:0]  in_rd,
   input  logic [1:0]  in_shift,
   input  logic [7:0]  in_imm8,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [1:0]  alu_op,
   input  logic [15:0] alu_out,
   input  logic        alu_z,
   output logic [15:0] c_out,
   output logic        z_flag,
   output logic        done,
   input  logic [2:0]  dbg_sel,
   output logic [15:0] dbg_data
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_LOAD_A = 3'd1;
   localparam logic [2:0] c_LOAD_B = 3'd2;
   localparam logic [2:0] c_EXEC   = 3'd3;
   localparam logic [2:0] c_WRITE  = 3'd4;

   localparam logic [1:0] c_KIND_ALU  = 2'b00;
   localparam logic [1:0] c_KIND_MOVR = 2'b01;
   localparam logic [1:0] c_KIND_MOVI = 2'b10;
   localparam logic [1:0] c_KIND_NOP  = 2'b11;
   localparam logic [1:0] c_OP_CMP    = 2'b01;

   logic [2:0]  r_state;
   logic [2:0]  w_next_state;
   logic        w_accept;
   logic        w_load_a;
   logic        w_load_b;
   logic        w_exec;
   logic        w_write;
   logic        w_wr_en;

   logic [1:0]  r_kind;
   logic [1:0]  r_aluop;
   logic [2:0]  r_rn;
   logic [2:0]  r_rm;
   logic [2:0]  r_rd;
   logic [1:0]  r_shift;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_c;
   logic        r_z;
   logic [15:0] r_regs [8];
   logic [15:0] w_b_shifted;

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (in_valid) begin
               if (in_kind == c_KIND_ALU || in_kind == c_KIND_MOVR) w_next_state = c_LOAD_A;
               else                                                   w_next_state = c_WRITE;
            end
         end
         c_LOAD_A: w_next_state = c_LOAD_B;
         c_LOAD_B: w_next_state = c_EXEC;
         c_EXEC:   w_next_state = c_WRITE;
         c_WRITE:  w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == c_IDLE);
      done     = (r_state == c_WRITE);
      w_accept = in_ready && in_valid;
      w_load_a = (r_state == c_LOAD_A);
      w_load_b = (r_state == c_LOAD_B);
      w_exec   = (r_state == c_EXEC);
      w_write  = (r_state == c_WRITE);
   end

   // CMP and the reserved kind complete without touching the register file.
   assign w_wr_en = w_write && (r_kind != c_KIND_NOP)
                    && !(r_kind == c_KIND_ALU && r_aluop == c_OP_CMP);

   always_comb begin
      w_b_shifted = r_b;
      case (r_shift)
         2'b01:   w_b_shifted = {r_b[14:0], 1'b0};
         2'b10:   w_b_shifted = {1'b0, r_b[15:1]};
         2'b11:   w_b_shifted = {r_b[15], r_b[15:1]};
         default: w_b_shifted = r_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_kind  <= 2'b00;
         r_aluop <= 2'b00;
         r_rn    <= 3'd0;
         r_rm    <= 3'd0;
         r_rd    <= 3'd0;
         r_shift <= 2'b00;
         r_a     <= 16'h0000;
         r_b     <= 16'h0000;
         r_c     <= 16'h0000;
         r_z     <= 1'b0;
         for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
      end else begin
         if (w_accept) begin
            r_kind  <= in_kind;
            r_aluop <= in_aluop;
            r_rn    <= in_rn;
            r_rm    <= in_rm;
            r_rd    <= in_rd;
            r_shift <= in_shift;
            if (in_kind == c_KIND_MOVI) r_c <= {{8{in_imm8[7]}}, in_imm8};
         end
         if (w_load_a) r_a <= (r_kind == c_KIND_ALU) ? r_regs[r_rn] : 16'h0000;
         if (w_load_b) r_b <= r_regs[r_rm];
         if (w_exec) begin
            r_c <= alu_out;
            if (r_kind == c_KIND_ALU) r_z <= alu_z;
         end
         if (w_wr_en) r_regs[r_rd] <= r_c;
      end
   end

   assign alu_a    = r_a;
   assign alu_b    = w_b_shifted;
   assign alu_op   = (r_kind == c_KIND_ALU) ? r_aluop : 2'b00;
   assign c_out    = r_c;
   assign z_flag   = r_z;
   assign dbg_data = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_sequencer
// Brief    : Directed self-checking bench with a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_kind = 2'b00;
   logic [1:0]  in_aluop = 2'b00;
   logic [2:0]  in_rn = 3'd0;
   logic [2:0]  in_rm = 3'd0;
   logic [2:0]  in_rd = 3'd0;
   logic [1:0]  in_shift = 2'b00;
   logic [7:0]  in_imm8 = 8'h00;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_op;
   logic [15:0] alu_out;
   logic        alu_z;
   logic [15:0] c_out;
   logic        z_flag;
   logic        done;
   logic [2:0]  dbg_sel = 3'd0;
   logic [15:0] dbg_data;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   alu_operand_sequencer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_aluop(in_aluop), .in_rn(in_rn), .in_rm(in_rm),
      .in_rd(in_rd), .in_shift(in_shift), .in_imm8(in_imm8),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_z(alu_z), .c_out(c_out), .z_flag(z_flag),
      .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #10 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return ~b;
      endcase
   endfunction

   // The external ALU is part of the environment.
   assign alu_out = alu_f(alu_op, alu_a, alu_b);
   assign alu_z   = (alu_out == 16'h0000);

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
      case (s)
         2'b01:   return 16'((32'(v) * 2) % 65536);
         2'b10:   return v / 16'd2;
         2'b11:   return (v / 16'd2) + (v >= 16'h8000 ? 16'h8000 : 16'h0000);
         default: return v;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: results computed at accept, committed when the instruction retires.
   logic [15:0] m_r [8];
   logic [15:0] m_c = 16'h0, p_c = 16'h0, e_a = 16'h0, e_b = 16'h0;
   logic        m_z = 1'b0, p_z = 1'b0, p_wr = 1'b0, m_exec = 1'b0, m_just_reset = 1'b0;
   logic [2:0]  p_rd = 3'd0;
   logic [1:0]  e_op = 2'b00;
   int          m_cnt = 0;

   initial begin
      logic [15:0] a, b, res;
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
            m_c = 16'h0; m_z = 1'b0; m_cnt = 0; m_exec = 1'b0; m_just_reset = 1'b1;
         end else begin
            m_just_reset = 1'b0;
            if (m_cnt == 0) begin
               if (in_valid) begin
                  b = shf(m_r[in_rm], in_shift);
                  p_rd = in_rd;
                  case (in_kind)
                     2'b00: begin
                        a = m_r[in_rn]; res = alu_f(in_aluop, a, b);
                        p_c = res; p_z = (res == 16'h0); p_wr = (in_aluop != 2'b01);
                        m_cnt = 4; m_exec = 1'b1; e_a = a; e_b = b; e_op = in_aluop;
                     end
                     2'b01: begin
                        p_c = b; p_z = m_z; p_wr = 1'b1;
                        m_cnt = 4; m_exec = 1'b1; e_a = 16'h0; e_b = b; e_op = 2'b00;
                     end
                     2'b10: begin
                        p_c = {{8{in_imm8[7]}}, in_imm8}; p_z = m_z; p_wr = 1'b1;
                        m_cnt = 1; m_exec = 1'b0;
                     end
                     default: begin
                        p_c = m_c; p_z = m_z; p_wr = 1'b0; m_cnt = 1; m_exec = 1'b0;
                     end
                  endcase
               end
            end else begin
               m_cnt--;
               if (m_cnt == 0) begin
                  if (p_wr) m_r[p_rd] = p_c;
                  m_c = p_c; m_z = p_z;
               end
            end
         end
      end
   end

   // Every-cycle comparison of DUT against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (m_just_reset) begin
               chk("rst_alu_a", alu_a, 16'h0);
               chk("rst_alu_b", alu_b, 16'h0);
               chk("rst_alu_op", {14'd0, alu_op}, 16'h0);
            end
            chk("in_ready", {15'd0, in_ready}, {15'd0, m_cnt == 0});
            chk("done", {15'd0, done}, {15'd0, m_cnt == 1});
            if (m_cnt == 2 && m_exec) begin
               chk("exec_alu_a", alu_a, e_a);
               chk("exec_alu_b", alu_b, e_b);
               chk("exec_alu_op", {14'd0, alu_op}, {14'd0, e_op});
            end
            if (m_cnt == 0) begin
               chk("c_out", c_out, m_c);
               chk("z_flag", {15'd0, z_flag}, {15'd0, m_z});
               for (int i = 0; i < 8; i++) begin
                  dbg_sel = 3'(i);
                  #1;
                  chk($sformatf("dbg_r%0d", i), dbg_data, m_r[i]);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 30);
      chk("idle_timeout", {15'd0, in_ready}, 16'd1);
   endtask

   task automatic drive(input logic [1:0] k, input logic [1:0] op, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [2:0] rd, input logic [1:0] sh,
                        input logic [7:0] imm);
      in_kind = k; in_aluop = op; in_rn = rn; in_rm = rm; in_rd = rd;
      in_shift = sh; in_imm8 = imm; in_valid = 1'b1;
   endtask

   task automatic issue(input logic [1:0] k, input logic [1:0] op, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [2:0] rd, input logic [1:0] sh,
                        input logic [7:0] imm);
      drive(k, op, rn, rm, rd, sh, imm);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("lit_rst_c", c_out, 16'h0);
      chk("lit_rst_z", {15'd0, z_flag}, 16'h0);

      issue(2'b10, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 8'h05);   // MOV r0,#5
      chk("lit_r0", m_r[0], 16'h0005);
      issue(2'b10, 2'b00, 3'd0, 3'd0, 3'd1, 2'b00, 8'hFE);   // MOV r1,#-2
      chk("lit_r1", m_r[1], 16'hFFFE);
      chk("lit_c_movi", c_out, 16'hFFFE);

      issue(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 2'b01, 8'h00);   // ADD r2,r0,r1 LSL1
      chk("lit_r2_add", m_r[2], 16'h0001);
      chk("lit_z_add", {15'd0, z_flag}, 16'h0);

      issue(2'b00, 2'b01, 3'd0, 3'd0, 3'd7, 2'b00, 8'h00);   // CMP r0,r0
      chk("lit_z_cmp", {15'd0, z_flag}, 16'h1);
      chk("lit_c_cmp", c_out, 16'h0000);
      chk("lit_r7_cmp", m_r[7], 16'h0000);

      issue(2'b01, 2'b10, 3'd5, 3'd1, 3'd3, 2'b11, 8'h00);   // MOV r3,r1 ASR1
      chk("lit_r3", m_r[3], 16'hFFFF);
      chk("lit_z_movr", {15'd0, z_flag}, 16'h1);

      issue(2'b00, 2'b11, 3'd0, 3'd0, 3'd4, 2'b00, 8'h00);   // MVN r4,r0
      chk("lit_r4", m_r[4], 16'hFFFA);
      issue(2'b00, 2'b10, 3'd0, 3'd4, 3'd5, 2'b00, 8'h00);   // AND r5,r0,r4
      chk("lit_r5", m_r[5], 16'h0000);
      chk("lit_z_and", {15'd0, z_flag}, 16'h1);

      // Valid held high with changing fields while busy: only the accepted ADD executes.
      drive(2'b00, 2'b00, 3'd2, 3'd2, 3'd6, 2'b01, 8'h00);   // ADD r6,r2,r2 LSL1
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         drive(2'b10, 2'(j), 3'(j), 3'(j + 1), 3'd7, 2'(j), 8'(8'h55 + j));
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("lit_hold_ready", {15'd0, in_ready}, 16'h1);
      chk("lit_r6_hold", m_r[6], 16'h0003);
      chk("lit_r7_hold", m_r[7], 16'h0000);

      issue(2'b00, 2'b00, 3'd2, 3'd2, 3'd2, 2'b00, 8'h00);   // ADD r2,r2,r2
      chk("lit_r2_overlap", m_r[2], 16'h0002);
      issue(2'b11, 2'b00, 3'd0, 3'd0, 3'd2, 2'b00, 8'h77);   // reserved no-op
      chk("lit_r2_nop", m_r[2], 16'h0002);
      chk("lit_c_nop", c_out, 16'h0002);

      // Reset while the ADD r6 is in EXEC.
      drive(2'b00, 2'b00, 3'd0, 3'd0, 3'd6, 2'b00, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("lit_abort_ready", {15'd0, in_ready}, 16'h1);
      chk("lit_abort_done", {15'd0, done}, 16'h0);
      chk("lit_abort_r6", m_r[6], 16'h0000);
      chk("lit_abort_c", c_out, 16'h0000);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
